operand_selector: RTL
=====================

OPERAND_SELECTOR -- requirements
Module: operand_selector

Interface
REQ-001 clk  input  1  system clock; all logic on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 start_select  input  1  one-cycle request pulse from the control FSM.
REQ-004 manual_mode  input  1  1 = user picks IDs, 0 = automatic pick; sampled on start_select.
REQ-005 op_sel  input  3  operation code; sampled on start_select.
REQ-006 id_sw  input  4  manual matrix ID from switches; sampled on key_ok.
REQ-007 key_ok  input  1  debounced one-cycle confirm pulse.
REQ-008 valid_mask  input  16  bit i = 1 means matrix slot i holds a stored matrix.
REQ-009 dim_rd_id  output  4  slot address for the dimension read port.
REQ-010 dim_rd_rows, dim_rd_cols  input  3 each  dimensions of slot dim_rd_id, valid one cycle after the address is driven.
REQ-011 selected_a, selected_b  output  4 each  chosen operand IDs.
REQ-012 select_done  output  1  level; operands valid and compatible.
REQ-013 select_error  output  1  level; the selection failed.
REQ-014 busy  output  1  high in any state other than IDLE, DONE or ERR.

Function
REQ-015 The operation classes SHALL be:
- 0 transpose: unary.
- 1 add: binary; requires equal rows and equal cols.
- 2 scalar multiply: unary.
- 3 matrix multiply: binary; requires cols(A) == rows(B).
- 4-7: reserved.
REQ-016 The states SHALL be IDLE, PICK_A, PICK_B, SCAN_A, SCAN_B, RD_A, RD_B, CHECK, DONE and ERR.
REQ-017 On start_select from any state, the block SHALL latch manual_mode and op_sel, clear select_done and select_error, and enter the next state. This aborts any operation in progress.
- Reserved op: ERR.
- manual_mode = 1: PICK_A.
- manual_mode = 0: SCAN_A, with the scan index at 0.
REQ-018 PICK_A SHALL wait for key_ok, then latch id_sw into selected_a.
- valid_mask[id_sw] = 0: ERR.
- Otherwise, unary op: selected_b <= selected_a and go to RD_A.
- Otherwise, binary op: go to PICK_B.
REQ-019 PICK_B SHALL wait for key_ok, then latch id_sw into selected_b.
- The slot is empty: ERR.
- Otherwise: RD_A.
- selected_b equal to selected_a is legal.
REQ-020 SCAN_A SHALL test one index per cycle, starting at 0.
- First set bit: latch it as selected_a. Unary op: selected_b <= selected_a and go to RD_A. Binary op: go to SCAN_B, starting at selected_a + 1.
- Index 15 tested with no hit: ERR.
REQ-021 SCAN_B SHALL test one index per cycle upward and latch the first set bit as selected_b, then go to RD_A.
- Index 15 tested with no hit: ERR. The scan does not wrap.
REQ-022 RD_A SHALL drive dim_rd_id = selected_a for exactly 2 cycles and latch rows_a/cols_a on the 2nd cycle. RD_B SHALL do the same for selected_b. The path is RD_A -> RD_B -> CHECK.
REQ-023 CHECK SHALL take 1 cycle and go to DONE if the op's rule holds, else ERR.
- Unary ops always pass if both dims are nonzero.
- A zero dimension on either operand: ERR.
REQ-024 In DONE, select_done SHALL be 1, and selected_a/b SHALL be held until the next start_select or rst.
REQ-025 In ERR, select_error SHALL be 1, selected_a/b SHALL keep their last latched values, and the block SHALL leave ERR only on start_select or rst.
REQ-026 key_ok SHALL be ignored outside PICK_A and PICK_B. id_sw SHALL be ignored except in the cycle key_ok is high.
REQ-027 valid_mask SHALL be sampled live in each PICK or SCAN cycle and not re-checked after it.
REQ-028 select_done and select_error SHALL never both be 1.
REQ-029 Cycle cost:
- Auto mode: from start_select to DONE/ERR is at most 16 + 16 + 2 + 2 + 1 + 1 cycles.
- Manual mode: after the last key_ok, DONE/ERR follows in 6 cycles.

Reset
REQ-030 While rst = 1 the block SHALL be in IDLE with every output 0: selected_a, selected_b, dim_rd_id, select_done, select_error and busy. This applies mid-operation too; rst overrides a simultaneous start_select.

Verification
REQ-031 Auto add: valid_mask = 0x0003, both slots 2x3, start_select with op 1 -> selected_a = 0, selected_b = 1, select_done = 1, busy low.
REQ-032 Auto multiply, incompatible: valid_mask = 0x0014, slot 2 is 2x3, slot 4 is 2x2, op 3 -> A = 2, B = 4, select_error = 1, select_done = 0.
REQ-033 Manual transpose: key_ok with id_sw = 5 and valid_mask[5] = 1 (3x1) -> selected_a = selected_b = 5, select_done = 1 six cycles after key_ok.
REQ-034 Manual empty slot: op 1, key_ok with id_sw = 7 and valid_mask[7] = 0 -> select_error next cycle; a further key_ok has no effect.
REQ-035 Boundaries:
- Auto binary with valid_mask = 0x8000 -> A = 15, then ERR.
- op_sel = 6 -> ERR one cycle after start_select.
REQ-036 Abort: start_select during SCAN_A with valid_mask = 0 -> restarts with flags cleared; rst mid-RD_B -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/operand_selector_if.sv
// Request/operand bus between the control FSM, the matrix store and operand_selector.
// The master side is the control/store environment; the slave side is the selector.
interface operand_selector_if;
   localparam int unsigned ID_W   = 4;
   localparam int unsigned DIM_W  = 3;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned SLOT_N = 16;

   logic              start_select;
   logic              manual_mode;
   logic [OP_W-1:0]   op_sel;
   logic [ID_W-1:0]   id_sw;
   logic              key_ok;
   logic [SLOT_N-1:0] valid_mask;
   logic [ID_W-1:0]   dim_rd_id;
   logic [DIM_W-1:0]  dim_rd_rows;
   logic [DIM_W-1:0]  dim_rd_cols;
   logic [ID_W-1:0]   selected_a;
   logic [ID_W-1:0]   selected_b;
   logic              select_done;
   logic              select_error;
   logic              busy;

   modport master (
      output start_select, manual_mode, op_sel, id_sw, key_ok, valid_mask,
             dim_rd_rows, dim_rd_cols,
      input  dim_rd_id, selected_a, selected_b, select_done, select_error, busy
   );

   modport slave (
      input  start_select, manual_mode, op_sel, id_sw, key_ok, valid_mask,
             dim_rd_rows, dim_rd_cols,
      output dim_rd_id, selected_a, selected_b, select_done, select_error, busy
   );
endinterface

// File: rtl/operand_selector.sv
// Picks one or two matrix operands (manually or by scanning the valid mask),
// reads their dimensions and checks them against the requested operation.
module operand_selector (
   input logic                clk,
   input logic                rst,
   operand_selector_if.slave  sel
);
   localparam int unsigned ID_W  = 4;
   localparam int unsigned DIM_W = 3;
   localparam int unsigned OP_W  = 3;
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(15);

   typedef enum logic [3:0] {
      IDLE, PICK_A, PICK_B, SCAN_A, SCAN_B, RD_A, RD_B, CHECK, DONE, ERR
   } state_t;

   state_t            state_q, state_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [ID_W-1:0]   scan_q, scan_d;
   logic [ID_W-1:0]   sel_a_q, sel_a_d, sel_b_q, sel_b_d;
   logic [ID_W-1:0]   rd_id_q, rd_id_d;
   logic              rd_cnt_q, rd_cnt_d;
   logic [DIM_W-1:0]  rows_a_q, rows_a_d, cols_a_q, cols_a_d;
   logic [DIM_W-1:0]  rows_b_q, rows_b_d, cols_b_q, cols_b_d;
   logic              done_q, done_d, err_q, err_d, busy_q, busy_d;
   logic              binary_c;
   logic              dims_ok_c;

   assign binary_c = (op_q == OP_W'(1)) || (op_q == OP_W'(3));

   // Operation-specific dimension rule; unary ops only need nonzero dims
   always_comb begin
      dims_ok_c = (rows_a_q != '0) && (cols_a_q != '0) &&
                  (rows_b_q != '0) && (cols_b_q != '0);
      case (op_q)
         OP_W'(1): dims_ok_c = dims_ok_c && (rows_a_q == rows_b_q) && (cols_a_q == cols_b_q);
         OP_W'(3): dims_ok_c = dims_ok_c && (cols_a_q == rows_b_q);
         default:  dims_ok_c = dims_ok_c;
      endcase
   end

   // Next-state and next-register values
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      scan_d   = scan_q;
      sel_a_d  = sel_a_q;
      sel_b_d  = sel_b_q;
      rd_cnt_d = 1'b0;
      rows_a_d = rows_a_q;
      cols_a_d = cols_a_q;
      rows_b_d = rows_b_q;
      cols_b_d = cols_b_q;

      case (state_q)
         PICK_A: if (sel.key_ok) begin
            sel_a_d = sel.id_sw;
            if (!sel.valid_mask[sel.id_sw]) state_d = ERR;
            else if (binary_c)               state_d = PICK_B;
            else begin
               sel_b_d = sel.id_sw;
               state_d = RD_A;
            end
         end
         PICK_B: if (sel.key_ok) begin
            sel_b_d = sel.id_sw;
            state_d = sel.valid_mask[sel.id_sw] ? RD_A : ERR;
         end
         SCAN_A: begin
            if (sel.valid_mask[scan_q]) begin
               sel_a_d = scan_q;
               if (!binary_c) begin
                  sel_b_d = scan_q;
                  state_d = RD_A;
               end else if (scan_q == LAST_ID) begin
                  state_d = ERR;
               end else begin
                  scan_d  = scan_q + ID_W'(1);
                  state_d = SCAN_B;
               end
            end else if (scan_q == LAST_ID) begin
               state_d = ERR;
            end else begin
               scan_d = scan_q + ID_W'(1);
            end
         end
         SCAN_B: begin
            if (sel.valid_mask[scan_q]) begin
               sel_b_d = scan_q;
               state_d = RD_A;
            end else if (scan_q == LAST_ID) begin
               state_d = ERR;
            end else begin
               scan_d = scan_q + ID_W'(1);
            end
         end
         // Dimensions arrive one cycle after the address, so latch on the 2nd cycle
         RD_A: begin
            if (rd_cnt_q) begin
               rows_a_d = sel.dim_rd_rows;
               cols_a_d = sel.dim_rd_cols;
               state_d  = RD_B;
            end else begin
               rd_cnt_d = 1'b1;
            end
         end
         RD_B: begin
            if (rd_cnt_q) begin
               rows_b_d = sel.dim_rd_rows;
               cols_b_d = sel.dim_rd_cols;
               state_d  = CHECK;
            end else begin
               rd_cnt_d = 1'b1;
            end
         end
         CHECK:   state_d = dims_ok_c ? DONE : ERR;
         default: state_d = state_q;
      endcase

      // A new request aborts whatever is in progress
      if (sel.start_select) begin
         op_d     = sel.op_sel;
         scan_d   = '0;
         rd_cnt_d = 1'b0;
         if (sel.op_sel[OP_W-1])   state_d = ERR;
         else if (sel.manual_mode) state_d = PICK_A;
         else                      state_d = SCAN_A;
      end

      rd_id_d = (state_d == RD_A) ? sel_a_d :
                (state_d == RD_B) ? sel_b_d : '0;
      done_d  = (state_d == DONE);
      err_d   = (state_d == ERR);
      busy_d  = !((state_d == IDLE) || (state_d == DONE) || (state_d == ERR));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         scan_q   <= '0;
         sel_a_q  <= '0;
         sel_b_q  <= '0;
         rd_id_q  <= '0;
         rd_cnt_q <= 1'b0;
         rows_a_q <= '0;
         cols_a_q <= '0;
         rows_b_q <= '0;
         cols_b_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         scan_q   <= scan_d;
         sel_a_q  <= sel_a_d;
         sel_b_q  <= sel_b_d;
         rd_id_q  <= rd_id_d;
         rd_cnt_q <= rd_cnt_d;
         rows_a_q <= rows_a_d;
         cols_a_q <= cols_a_d;
         rows_b_q <= rows_b_d;
         cols_b_q <= cols_b_d;
         done_q   <= done_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
      end
   end

   assign sel.dim_rd_id    = rd_id_q;
   assign sel.selected_a   = sel_a_q;
   assign sel.selected_b   = sel_b_q;
   assign sel.select_done  = done_q;
   assign sel.select_error = err_q;
   assign sel.busy         = busy_q;
endmodule
